// File: rtl/mm2_drain_ctrl.sv
// rtl/mm2_drain_ctrl.sv - read-side drain sequencer for the layer-2 result buffer
//
// Walks mem_read_addr 0..DEPTH-1 after a start pulse. It absorbs the buffer's
// one-cycle registered read latency. Every word is streamed downstream through
// a 2-entry skid buffer with full valid/ready backpressure.
//
// Optional feature macro: MM2_DRAIN_ARGMAX_EN (adds max_value/max_index).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle drain request, honoured only in IDLE
//   busy, done      busy while draining, one-cycle done pulse at the end
//   mem_read_addr   registered read address to the buffer
//   mem_data        buffer read data, valid one edge after the address
//   out_data        stream word (signed)
//   out_index       buffer address of out_data
//   out_valid       stream valid
//   out_last        marks the beat with index DEPTH-1
//   out_ready       consumer accept
//   max_value       running signed maximum (MM2_DRAIN_ARGMAX_EN only)
//   max_index       index of the earliest maximum (MM2_DRAIN_ARGMAX_EN only)
module mm2_drain_ctrl #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        mem_read_addr,
    input  logic signed [DATA_W-1:0] mem_data,
    output logic signed [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready
`ifdef MM2_DRAIN_ARGMAX_EN
    ,
    output logic signed [DATA_W-1:0] max_value,
    output logic [ADDR_W-1:0]        max_index
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] rd_cnt;
    logic              pend;        // a word is arriving on mem_data this cycle
    logic [ADDR_W-1:0] pend_idx;    // buffer address of that word
    logic [1:0]        count;       // skid buffer occupancy
    logic signed [DATA_W-1:0] e0_data, e1_data;
    logic [ADDR_W-1:0]        e0_idx,  e1_idx;
    logic                     e0_last, e1_last;

    logic       issue;
    logic       pop;
    logic [2:0] fill;

    assign pop  = out_valid && out_ready;
    // Occupancy after this edge, not counting a read issued on this edge.
    // Crediting the pop lets a read issue while the head drains, which
    // sustains one beat per cycle.
    assign fill = {1'b0, count} + {2'b00, pend} - {2'b00, pop};

    assign mem_read_addr = rd_cnt;
    assign out_valid     = (count != 2'd0);
    assign out_data      = e0_data;
    assign out_index     = e0_idx;
    assign out_last      = e0_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (fill < 3'd2) begin
                    issue = 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        next_state = FLUSH;
                    end
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (count == 2'd0 && !pend) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Read issue. The address is registered, and the buffer samples it on the
    // edge where issue is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt   <= '0;
            pend     <= 1'b0;
            pend_idx <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_idx <= rd_cnt;
            end
            if (state == IDLE && start) begin
                rd_cnt <= '0;
            end else if (issue && rd_cnt != LAST_IDX) begin
                rd_cnt <= rd_cnt + ADDR_W'(1);
            end
        end
    end

    // Skid buffer. e0 is the head. A push goes to the first free slot after
    // any simultaneous pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 2'd0;
            e0_data <= '0;
            e0_idx  <= '0;
            e0_last <= 1'b0;
            e1_data <= '0;
            e1_idx  <= '0;
            e1_last <= 1'b0;
        end else begin
            count <= fill[1:0];
            case ({pend, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        e0_data <= mem_data;
                        e0_idx  <= pend_idx;
                        e0_last <= (pend_idx == LAST_IDX);
                    end else begin
                        e1_data <= mem_data;
                        e1_idx  <= pend_idx;
                        e1_last <= (pend_idx == LAST_IDX);
                    end
                end
                2'b01: begin
                    e0_data <= e1_data;
                    e0_idx  <= e1_idx;
                    e0_last <= e1_last;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0_data <= mem_data;
                        e0_idx  <= pend_idx;
                        e0_last <= (pend_idx == LAST_IDX);
                    end else begin
                        e0_data <= e1_data;
                        e0_idx  <= e1_idx;
                        e0_last <= e1_last;
                        e1_data <= mem_data;
                        e1_idx  <= pend_idx;
                        e1_last <= (pend_idx == LAST_IDX);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MM2_DRAIN_ARGMAX_EN
    // The strict compare keeps the earliest index on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_value <= '0;
            max_index <= '0;
        end else if (state == IDLE && start) begin
            max_value <= {1'b1, {(DATA_W-1){1'b0}}};
            max_index <= '0;
        end else if (pop && (out_data > max_value)) begin
            max_value <= out_data;
            max_index <= out_index;
        end
    end
`endif

endmodule

// File: doc/mm2_drain_ctrl.md
# mm2_drain_ctrl

Read-side sequencer for the 64-entry layer-2 result buffer (`mm2_memory`). On a start pulse it walks the read address from 0 to DEPTH-1 and absorbs the buffer's one-cycle registered read latency. It streams every word to the downstream stage (ReLU/argmax/UART) over a valid/ready handshake with full backpressure support. It sits between the layer-2 matmul engine, which pulses `start` after its final write, and the result consumer.

## Interface
- `DEPTH`, 64, number of words drained per run (2..65535)
- `ADDR_W`, 16, width of buffer address and beat index
- `DATA_W`, 32, signed data width
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request to drain; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `mem_read_addr`  out  ADDR_W  to the buffer's `read_addr`
- `mem_data`  in  DATA_W signed  from the buffer's `data_out`; valid one edge after the address
- `out_data`  out  DATA_W signed  stream word
- `out_index`  out  ADDR_W  buffer address of `out_data`
- `out_valid`  out  1  stream valid
- `out_last`  out  1  high with the beat whose index is DEPTH-1
- `out_ready`  in  1  consumer accept
- `max_value`  out  DATA_W signed  only with MM2_DRAIN_ARGMAX_EN
- `max_index`  out  ADDR_W  only with MM2_DRAIN_ARGMAX_EN

## Operation
- FSM states:
  - IDLE: `start` → RUN; clear counters.
  - RUN: issue reads.
  - FLUSH: all reads issued; wait for the output buffer to empty.
  - DONE: assert `done` for one cycle → IDLE.
- Issue counter `rd_cnt` drives `mem_read_addr` from a register.
  - In RUN, the address increments only when the 2-entry output skid buffer has room for the word in flight: occupancy + in-flight < 2.
  - RUN → FLUSH when `rd_cnt` has issued DEPTH-1.
- A word returning from the buffer is written into the skid buffer together with its index. The head of the skid buffer drives `out_*`.
- Handshake: a beat transfers on an edge with `out_valid && out_ready`.
  - `out_data`, `out_index` and `out_last` must hold stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
- Every index 0..DEPTH-1 is emitted exactly once, in ascending order. There are no duplicates and no gaps under any `out_ready` pattern.
- `start` while not IDLE is ignored and has no side effects.
- The block never writes the buffer. The producer must not write during `busy`; this is not checked.
- `rst` asserted at any time, including mid-drain:
  - state returns to IDLE;
  - skid buffer is emptied;
  - all outputs go to 0, including `mem_read_addr`.
  - The next `start` drains from index 0.

## Timing
- Reset value of every output is 0.
- `start` sampled at edge E0: `busy=1` and `mem_read_addr=0` after E0.
- The buffer samples the address at E1 and word 0 is captured at E2, so `out_valid` rises after E2. First-beat latency is 2 cycles.
- With `out_ready` held high, one beat per cycle is sustained. Beat k is presented after edge E2+k, so the last beat is presented after E2+DEPTH-1.
- The last beat is accepted at edge EL. `done=1` and `busy=0` after EL+1. `done` is low one cycle later.
- Throughput is restored on the first cycle `out_ready` returns high, with no bubble.

## Configuration
- `MM2_DRAIN_ARGMAX_EN` defined:
  - A running signed argmax is updated on each accepted beat. A strictly-greater compare keeps the earliest index on ties.
  - On `start`, `max_value` is reset to the most negative value and `max_index` to 0.
  - Both outputs are final when `done` pulses and are held until the next accepted `start`. Both reset to 0 under `rst`.
- Not defined: `max_value`/`max_index` ports and the comparator are absent. Streaming behaviour is identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately, FSM in IDLE, `start` ignored while `rst` is high.
- Full drain, `out_ready=1`, buffer preloaded with word[i]=3*i-50:
  - 64 beats with values -50..139 and indices 0..63;
  - first `out_valid` 2 cycles after `start`;
  - `out_last` only on index 63;
  - `done` 1 cycle after the last accept.
- Backpressure: `out_ready` pseudo-random at 30% duty → identical 64-word sequence, outputs stable while stalled, no beat lost or repeated, at most 2 words in flight.
- `start` pulsed at beat 10 of an active drain → ignored: single `done`, exactly 64 beats.
- `rst` at beat 20, then a new `start` → stream restarts at index 0 and completes all 64 beats.
- With `MM2_DRAIN_ARGMAX_EN`: word[5]=word[40]=0x7FFF_FFF0 and all others smaller → at `done`, `max_value`=0x7FFF_FFF0 and `max_index`=5.
- With `MM2_DRAIN_ARGMAX_EN`: all words -1 → `max_index`=0.
